// File: rtl/hub75_rx.sv
// hub75_rx: HUB75 sink that rebuilds each shifted row and replays latched rows as a valid/ready pixel stream.
// Latency: pins act 3 clk after toggling; the first beat follows the latch edge by one cycle. Optional HUB75_RX_BLANK_STATS_EN adds blank-time statistics.
// Backpressure: out_* hold while out_valid & !out_ready; a latch arriving mid-stream is dropped and flagged as overrun.
module hub75_rx #(
  parameter int COLS   = 64,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               r,
  input  logic [1:0]               g,
  input  logic [1:0]               b,
  input  logic                     led_clk,
  input  logic                     latch,
  input  logic                     blank,
  input  logic [ADDR_W-1:0]        addr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [$clog2(COLS)-1:0]  out_col,
  output logic [2:0]               out_top,
  output logic [2:0]               out_bot,
  output logic                     out_last,
  output logic                     out_sof,
  output logic                     row_len_err,
  output logic                     overrun,
  output logic                     on_valid,
  output logic [ADDR_W-1:0]        on_addr,
  output logic [15:0]              on_cycles
);

  localparam int CW = $clog2(COLS);
  localparam int IW = CW + 1;
  localparam int SW = ADDR_W + 9;
  localparam logic [IW-1:0] COLS_I   = IW'(COLS);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  // Bus layout: {addr, blank, latch, led_clk, b, g, r}; one pipeline keeps data aligned with the clocks.
  logic [SW-1:0] bus_in, sync1, sync2;
  logic          led_q, latch_q;

  assign bus_in = {addr, blank, latch, led_clk, b, g, r};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      led_q   <= 1'b0;
      latch_q <= 1'b0;
    end else begin
      sync1   <= bus_in;
      sync2   <= sync1;
      led_q   <= sync2[6];
      latch_q <= sync2[7];
    end
  end

  logic              led_rise, latch_rise, blank_s;
  logic [ADDR_W-1:0] addr_s;
  logic [5:0]        pix;

  assign led_rise   = sync2[6] & ~led_q;
  assign latch_rise = sync2[7] & ~latch_q;
  assign blank_s    = sync2[8];
  assign addr_s     = sync2[SW-1:9];
  assign pix        = {sync2[0], sync2[2], sync2[4], sync2[1], sync2[3], sync2[5]};

  state_t state_q, state_d;
  logic   accept, reject, fire;

  assign accept = latch_rise && (state_q == IDLE);
  assign reject = latch_rise && (state_q == STREAM);
  assign fire   = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (latch_rise) state_d = STREAM;
      STREAM:  if (out_ready && out_col == LAST_COL) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture bank is cap_bank, readout bank is its complement; an accepted latch swaps them.
  logic [5:0]    mem [2*COLS];
  logic          cap_bank, wr_bank, wr_en;
  logic [IW-1:0] wr_idx, wr_base, wr_nxt;
  logic [5:0]    rd_dat;

  // A latch in the same cycle as a shift edge is handled first, so the pixel lands at index 0.
  assign wr_bank = accept ? ~cap_bank : cap_bank;
  assign wr_base = latch_rise ? '0 : wr_idx;
  assign wr_en   = led_rise && (wr_base < COLS_I);
  assign wr_nxt  = wr_base + {{(IW-1){1'b0}}, (led_rise && wr_base != COLS_I)};

  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[{wr_bank, wr_base[CW-1:0]}] <= pix;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx      <= '0;
      cap_bank    <= 1'b0;
      out_addr    <= '0;
      out_col     <= '0;
      row_len_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      wr_idx <= wr_nxt;
      if (accept) begin
        cap_bank <= ~cap_bank;
        out_addr <= addr_s;
        out_col  <= '0;
        if (wr_idx != COLS_I) row_len_err <= 1'b1;
      end else if (fire) begin
        out_col <= out_col + 1'b1;
      end
      if (reject) overrun <= 1'b1;
    end
  end

  assign rd_dat = mem[{~cap_bank, out_col}];

  always_comb begin
    out_valid = 1'b0;
    out_top   = '0;
    out_bot   = '0;
    out_last  = 1'b0;
    out_sof   = 1'b0;
    if (state_q == STREAM) begin
      out_valid = 1'b1;
      out_top   = rd_dat[5:3];
      out_bot   = rd_dat[2:0];
      out_last  = (out_col == LAST_COL);
      out_sof   = (out_col == '0) && (out_addr == '0);
    end
  end

`ifdef HUB75_RX_BLANK_STATS_EN
  logic [15:0]       blank_cnt;
  logic              seen_latch;
  logic [ADDR_W-1:0] last_addr;

  // Every latch edge, accepted or overrun, closes the current measurement window.
  always_ff @(posedge clk) begin
    if (rst) begin
      blank_cnt  <= '0;
      seen_latch <= 1'b0;
      last_addr  <= '0;
      on_valid   <= 1'b0;
      on_addr    <= '0;
      on_cycles  <= '0;
    end else begin
      on_valid <= 1'b0;
      if (latch_rise) begin
        if (seen_latch) begin
          on_valid  <= 1'b1;
          on_addr   <= last_addr;
          on_cycles <= blank_cnt;
        end
        seen_latch <= 1'b1;
        last_addr  <= addr_s;
        blank_cnt  <= '0;
      end else if (!blank_s && blank_cnt != 16'hFFFF) begin
        blank_cnt <= blank_cnt + 16'd1;
      end
    end
  end
`else
  logic unused_blank;
  assign unused_blank = blank_s;
  assign on_valid     = 1'b0;
  assign on_addr      = '0;
  assign on_cycles    = '0;
`endif

endmodule

// File: tb/tb_hub75_rx.sv
// Bench for hub75_rx: directed HUB75 rows, expected beats queued at stimulus time, checked by an independent monitor.
module tb_hub75_rx;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  r, g, b;
  logic        led_clk, latch, blank;
  logic [4:0]  addr;
  logic        out_valid, out_ready;
  logic [4:0]  out_addr;
  logic [5:0]  out_col;
  logic [2:0]  out_top, out_bot;
  logic        out_last, out_sof, row_len_err, overrun;
  logic        on_valid;
  logic [4:0]  on_addr;
  logic [15:0] on_cycles;

  int checks = 0;
  int errors = 0;

  hub75_rx #(.COLS(64), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .r(r), .g(g), .b(b),
    .led_clk(led_clk), .latch(latch), .blank(blank), .addr(addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_col(out_col), .out_top(out_top), .out_bot(out_bot),
    .out_last(out_last), .out_sof(out_sof),
    .row_len_err(row_len_err), .overrun(overrun),
    .on_valid(on_valid), .on_addr(on_addr), .on_cycles(on_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] addr;
    logic [5:0] col;
    logic [2:0] top;
    logic [2:0] bot;
    logic       last;
    logic       sof;
    logic       chk;
  } beat_t;

  beat_t exp_q[$];

  logic ready_level = 1'b1;
  logic ready_toggle = 1'b0;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = ready_toggle ? ~out_ready : ready_level;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [2:0] pat_top(input int p, input int c);
    logic [5:0] cc;
    cc = 6'(c);
    return (p == 0) ? cc[2:0] : cc[5:3];
  endfunction

  function automatic logic [2:0] pat_bot(input int p, input int c);
    logic [5:0] cc;
    cc = 6'(c);
    return (p == 0) ? ~cc[2:0] : (cc[2:0] ^ 3'b101);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  task automatic shift_row(input int n, input int p);
    logic [2:0] t, bt;
    for (int c = 0; c < n; c++) begin
      t  = pat_top(p, c);
      bt = pat_bot(p, c);
      r = {bt[2], t[2]};
      g = {bt[1], t[1]};
      b = {bt[0], t[0]};
      tick(2);
      led_clk = 1'b1;
      tick(2);
      led_clk = 1'b0;
    end
    tick(2);
  endtask

  task automatic push_row(input logic [4:0] a, input int p, input int nvalid);
    beat_t e;
    for (int c = 0; c < 64; c++) begin
      e.addr = a;
      e.col  = 6'(c);
      e.top  = pat_top(p, c);
      e.bot  = pat_bot(p, c);
      e.last = (c == 63);
      e.sof  = (c == 0) && (a == 5'd0);
      e.chk  = (c < nvalid);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_latch(input logic [4:0] a);
    addr = a;
    tick(2);
    latch = 1'b1;
    tick(2);
    latch = 1'b0;
    tick(2);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      tick(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s drain left=%0d want=0", name, exp_q.size());
    end
    tick(8);
  endtask

  // Monitor: pops on each handshake and checks that stalled beats do not change.
  logic       stall_prev = 1'b0;
  logic [4:0] p_addr;
  logic [5:0] p_col;
  logic [2:0] p_top, p_bot;
  logic       p_last, p_sof;
  logic       on_seen = 1'b0;
  int         on_pulses = 0;
  logic [4:0] on_addr_cap = '0;
  logic [15:0] on_cyc_cap = '0;

  always @(negedge clk) begin
    beat_t e;
    if (!rst) begin
      if (stall_prev) begin
        checks++;
        if (out_valid !== 1'b1 || out_addr !== p_addr || out_col !== p_col || out_top !== p_top ||
            out_bot !== p_bot || out_last !== p_last || out_sof !== p_sof) begin
          errors++;
          $display("FAIL stall_hold col got=%0d want=%0d top got=%0h want=%0h valid=%0b",
                   out_col, p_col, out_top, p_top, out_valid);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat col=%0d addr=%0d want=no beat", out_col, out_addr);
        end else begin
          e = exp_q.pop_front();
          if (out_addr !== e.addr || out_col !== e.col || out_last !== e.last || out_sof !== e.sof ||
              (e.chk && (out_top !== e.top || out_bot !== e.bot))) begin
            errors++;
            $display("FAIL beat got addr=%0d col=%0d top=%0h bot=%0h last=%0b sof=%0b want addr=%0d col=%0d top=%0h bot=%0h last=%0b sof=%0b",
                     out_addr, out_col, out_top, out_bot, out_last, out_sof,
                     e.addr, e.col, e.top, e.bot, e.last, e.sof);
          end
        end
      end
      if (on_valid) begin
        on_pulses++;
        on_addr_cap = on_addr;
        on_cyc_cap  = on_cycles;
      end
      on_seen = on_seen | on_valid | (|on_addr) | (|on_cycles);
    end
    stall_prev = out_valid && !out_ready && !rst;
    p_addr = out_addr; p_col = out_col; p_top = out_top; p_bot = out_bot;
    p_last = out_last; p_sof = out_sof;
  end

  initial begin
    int n;
    rst = 1'b1; r = '0; g = '0; b = '0; addr = '0;
    led_clk = 1'b1; latch = 1'b1; blank = 1'b1;
    tick(5);
    led_clk = 1'b0; latch = 1'b0;
    tick(4);
    rst = 1'b0;
    tick(1);
    chk("rst_valid",  32'(out_valid), 0);
    chk("rst_col",    32'(out_col), 0);
    chk("rst_addr",   32'(out_addr), 0);
    chk("rst_top",    32'(out_top), 0);
    chk("rst_bot",    32'(out_bot), 0);
    chk("rst_last",   32'(out_last), 0);
    chk("rst_sof",    32'(out_sof), 0);
    chk("rst_lenerr", 32'(row_len_err), 0);
    chk("rst_ovr",    32'(overrun), 0);
    chk("rst_onv",    32'(on_valid), 0);
    chk("rst_ona",    32'(on_addr), 0);
    chk("rst_onc",    32'(on_cycles), 0);
    tick(20);

    // Full row, addr 5, with latch-to-first-beat latency measured from the pin edge.
    shift_row(64, 0);
    push_row(5'd5, 0, 64);
    addr = 5'd5;
    tick(2);
    latch = 1'b1;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n < 3 || n > 4) begin
      errors++;
      $display("FAIL latch_to_valid got=%0d want=3..4", n);
    end
    tick(1);
    latch = 1'b0;
    tick(2);
    wait_drain("full_row");
    chk("full_lenerr", 32'(row_len_err), 0);
    chk("full_ovr",    32'(overrun), 0);

    // Row at addr 0 with out_ready toggling each cycle.
    ready_toggle = 1'b1;
    shift_row(64, 1);
    push_row(5'd0, 1, 64);
    do_latch(5'd0);
    wait_drain("bp_row");
    ready_toggle = 1'b0;
    tick(2);
    chk("bp_lenerr", 32'(row_len_err), 0);
    chk("bp_ovr",    32'(overrun), 0);

    // Short row: last entry is stale, still 64 beats.
    shift_row(63, 0);
    push_row(5'd6, 0, 63);
    do_latch(5'd6);
    wait_drain("short_row");
    chk("short_lenerr", 32'(row_len_err), 1);
    chk("short_ovr",    32'(overrun), 0);

    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    chk("rst2_lenerr", 32'(row_len_err), 0);
    chk("rst2_valid",  32'(out_valid), 0);

    // Overrun: row A stalls, row B latched mid-stream is discarded.
    ready_level = 1'b0;
    tick(1);
    shift_row(64, 1);
    push_row(5'd7, 1, 64);
    do_latch(5'd7);
    shift_row(64, 0);
    do_latch(5'd9);
    tick(2);
    chk("ovr_flag",   32'(overrun), 1);
    chk("ovr_lenerr", 32'(row_len_err), 0);
    chk("ovr_addr",   32'(out_addr), 7);
    ready_level = 1'b1;
    wait_drain("overrun_row");

    // Blank statistics: latch addr 3, 100 cycles of blank low, latch again.
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    on_pulses = 0;
    push_row(5'd3, 0, 0);
    do_latch(5'd3);
    wait_drain("blank_row_a");
    blank = 1'b0;
    tick(100);
    blank = 1'b1;
    tick(4);
    push_row(5'd4, 0, 0);
    do_latch(5'd4);
    wait_drain("blank_row_b");
`ifdef HUB75_RX_BLANK_STATS_EN
    chk("on_pulses", 32'(on_pulses), 1);
    chk("on_addr",   32'(on_addr_cap), 3);
    checks++;
    if (on_cyc_cap < 16'd99 || on_cyc_cap > 16'd101) begin
      errors++;
      $display("FAIL on_cycles got=%0d want=99..101", on_cyc_cap);
    end
`else
    chk("on_tied_zero", 32'(on_seen), 0);
    chk("on_pulses",    32'(on_pulses), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
